// File: rtl/sipo_frame_receiver.sv
// sipo_frame_receiver: LSB-first serial-to-parallel frame receiver with a
// one-entry valid/ready output slot and sticky overrun detection.
// Optional even-parity check enabled by defining SIPO_PARITY_EN.
module sipo_frame_receiver #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             SIn,
  input  logic             SIn_Valid,
  input  logic             Clear,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Overrun,
  output logic             Parity_Err,
  output logic             Busy
);

`ifdef SIPO_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CW = $clog2(FRAME);

  typedef enum logic {IDLE, RECV} rx_state_t;

  rx_state_t          r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_sh;
  logic [WIDTH-1:0]   r_data;
  logic               r_out_valid;
  logic               r_overrun;

  logic               w_accept;
  logic               w_last;
  logic               w_done;
  logic               w_shift;
  logic               w_load;
  logic [WIDTH-1:0]   w_word;

  assign w_accept = SIn_Valid && !Clear;
  // cnt can only reach FRAME-1 while in RECV since FRAME >= 2
  assign w_last   = (r_state == RECV) && (r_cnt == CW'(FRAME - 1));
  assign w_done   = w_accept && w_last;
  assign w_load   = w_done && (!r_out_valid || Out_Ready);

`ifdef SIPO_PARITY_EN
  logic r_perr;
  // parity bit is the final frame bit and never enters the shift register
  assign w_shift    = w_accept && !w_last;
  assign w_word     = r_sh;
  assign Parity_Err = r_perr;

  // parity status captured alongside Data_Out, dropped with it on overrun
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)      r_perr <= 1'b0;
    else if (w_load) r_perr <= (^r_sh) ^ SIn;
  end
`else
  assign w_shift    = w_accept;
  assign w_word     = {SIn, r_sh[WIDTH-1:1]};
  assign Parity_Err = 1'b0;
`endif

  // receive FSM state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // receive FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    if (Clear) begin
      w_state_nxt = IDLE;
    end else if (SIn_Valid) begin
      unique case (r_state)
        IDLE: w_state_nxt = RECV;
        RECV: if (w_last) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // bit counter: advances per accepted bit, wraps at frame end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)         r_cnt <= '0;
    else if (Clear)     r_cnt <= '0;
    else if (w_done)    r_cnt <= '0;
    else if (w_accept)  r_cnt <= r_cnt + 1'b1;
  end

  // LSB-first shift register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)        r_sh <= '0;
    else if (Clear)    r_sh <= '0;
    else if (w_shift)  r_sh <= {SIn, r_sh[WIDTH-1:1]};
  end

  // output slot: load on completion if free (or freed this cycle), else drain
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_data      <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_data      <= w_word;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && Out_Ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // sticky overrun: completion while slot full and not being drained
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)                                      r_overrun <= 1'b0;
    else if (Clear)                                  r_overrun <= 1'b0;
    else if (w_done && r_out_valid && !Out_Ready)    r_overrun <= 1'b1;
  end

  assign Data_Out  = r_data;
  assign Out_Valid = r_out_valid;
  assign Overrun   = r_overrun;
  assign Busy      = (r_cnt != '0);

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed self-checking bench for sipo_frame_receiver (WIDTH=4).
// Inputs change on the falling edge; outputs are checked on the following
// falling edge, after the rising edge that sampled the inputs.
module tb_sipo_frame_receiver;

`ifdef SIPO_PARITY_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic       SIn;
  logic       SIn_Valid;
  logic       Clear;
  logic [3:0] Data_Out;
  logic       Out_Valid;
  logic       Out_Ready;
  logic       Overrun;
  logic       Parity_Err;
  logic       Busy;

  int total = 0;
  int bad   = 0;

  sipo_frame_receiver #(.WIDTH(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .SIn        (SIn),
    .SIn_Valid  (SIn_Valid),
    .Clear      (Clear),
    .Data_Out   (Data_Out),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Overrun    (Overrun),
    .Parity_Err (Parity_Err),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(negedge Clock);
  endtask

  function automatic logic frame_bit(input logic [3:0] w, input int i);
    logic b;
    if (i < 4) b = w[i];
    else       b = ^w;
    return b;
  endfunction

  task automatic send_bit(input logic b);
    SIn = b;
    SIn_Valid = 1'b1;
    tick();
    SIn_Valid = 1'b0;
  endtask

  task automatic send_frame_p(input logic [3:0] w, input logic p);
    for (int i = 0; i < 4; i++) send_bit(w[i]);
`ifdef SIPO_PARITY_EN
    send_bit(p);
`else
    if (p === 1'bx) SIn = 1'b0;
`endif
  endtask

  task automatic send_frame(input logic [3:0] w);
    send_frame_p(w, ^w);
  endtask

  task automatic drain();
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; SIn = 1'b0; SIn_Valid = 1'b0; Clear = 1'b0; Out_Ready = 1'b0;
    #3;
    total++; if (Data_Out !== 4'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", Data_Out); end
    total++; if ({Out_Valid, Overrun, Parity_Err, Busy} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {Out_Valid, Overrun, Parity_Err, Busy}); end
    tick(); tick();
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    for (int i = 0; i < FRAME; i++) begin
      send_bit(frame_bit(4'hD, i));
      total++; if (Busy !== (i != FRAME - 1)) begin
        bad++; $display("FAIL basic_busy bit=%0d got=%b exp=%b", i, Busy, (i != FRAME - 1)); end
      total++; if (Out_Valid !== (i == FRAME - 1)) begin
        bad++; $display("FAIL basic_valid bit=%0d got=%b exp=%b", i, Out_Valid, (i == FRAME - 1)); end
    end
    total++; if (Data_Out !== 4'hD) begin bad++; $display("FAIL basic_data got=%h exp=d", Data_Out); end
    total++; if (Parity_Err !== 1'b0) begin bad++; $display("FAIL basic_perr got=%b exp=0", Parity_Err); end
    drain();
    total++; if (Out_Valid !== 1'b0 || Data_Out !== 4'hD) begin
      bad++; $display("FAIL basic_drain got=%b/%h exp=0/d", Out_Valid, Data_Out); end
  endtask

  task automatic test_gapped();
    send_bit(1'b1);
    send_bit(1'b0);
    for (int g = 0; g < 3; g++) begin
      SIn = g[0];
      tick();
      total++; if (Busy !== 1'b1 || Out_Valid !== 1'b0) begin
        bad++; $display("FAIL gap_hold cyc=%0d got=%b%b exp=10", g, Busy, Out_Valid); end
    end
    for (int i = 2; i < FRAME; i++) send_bit(frame_bit(4'hD, i));
    total++; if (Out_Valid !== 1'b1 || Data_Out !== 4'hD) begin
      bad++; $display("FAIL gap_data got=%b/%h exp=1/d", Out_Valid, Data_Out); end
    drain();
  endtask

  task automatic test_overrun();
    Out_Ready = 1'b0;
    send_frame(4'hA);
    total++; if (Out_Valid !== 1'b1 || Data_Out !== 4'hA || Overrun !== 1'b0) begin
      bad++; $display("FAIL ovr_first got=%b/%h/%b exp=1/a/0", Out_Valid, Data_Out, Overrun); end
    send_frame(4'h5);
    total++; if (Data_Out !== 4'hA) begin bad++; $display("FAIL ovr_keep got=%h exp=a", Data_Out); end
    total++; if (Overrun !== 1'b1 || Out_Valid !== 1'b1) begin
      bad++; $display("FAIL ovr_flag got=%b/%b exp=1/1", Overrun, Out_Valid); end
    tick();
    total++; if (Overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", Overrun); end
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    total++; if (Overrun !== 1'b0 || Out_Valid !== 1'b1 || Data_Out !== 4'hA) begin
      bad++; $display("FAIL ovr_clear got=%b/%b/%h exp=0/1/a", Overrun, Out_Valid, Data_Out); end
    drain();
  endtask

  task automatic test_drain_fill();
    Out_Ready = 1'b0;
    send_frame(4'h3);
    total++; if (Data_Out !== 4'h3 || Out_Valid !== 1'b1) begin
      bad++; $display("FAIL df_hold got=%h/%b exp=3/1", Data_Out, Out_Valid); end
    for (int i = 0; i < FRAME - 1; i++) send_bit(frame_bit(4'hC, i));
    Out_Ready = 1'b1;
    send_bit(frame_bit(4'hC, FRAME - 1));
    Out_Ready = 1'b0;
    total++; if (Data_Out !== 4'hC || Out_Valid !== 1'b1 || Overrun !== 1'b0) begin
      bad++; $display("FAIL df_swap got=%h/%b/%b exp=c/1/0", Data_Out, Out_Valid, Overrun); end
    drain();
  endtask

  task automatic test_reset_midframe();
    Out_Ready = 1'b0;
    send_frame(4'h9);
    send_bit(1'b1);
    send_bit(1'b1);
    Reset = 1'b0;
    #1;
    total++; if (Data_Out !== 4'h0 || {Out_Valid, Overrun, Parity_Err, Busy} !== 4'b0000) begin
      bad++; $display("FAIL rst_mid got=%h/%b exp=0/0000", Data_Out, {Out_Valid, Overrun, Parity_Err, Busy}); end
    tick();
    Reset = 1'b1;
    tick();
    send_frame(4'h6);
    total++; if (Data_Out !== 4'h6 || Out_Valid !== 1'b1) begin
      bad++; $display("FAIL rst_next got=%h/%b exp=6/1", Data_Out, Out_Valid); end
    drain();
  endtask

  task automatic test_clear_midframe();
    send_bit(1'b1);
    send_bit(1'b1);
    Clear = 1'b1;
    send_bit(1'b1);
    Clear = 1'b0;
    total++; if (Busy !== 1'b0 || Out_Valid !== 1'b0) begin
      bad++; $display("FAIL clr_mid got=%b%b exp=00", Busy, Out_Valid); end
    send_frame(4'h2);
    total++; if (Data_Out !== 4'h2 || Out_Valid !== 1'b1) begin
      bad++; $display("FAIL clr_next got=%h/%b exp=2/1", Data_Out, Out_Valid); end
    drain();
  endtask

  task automatic test_back_to_back();
    Out_Ready = 1'b1;
    send_frame(4'h9);
    total++; if (Data_Out !== 4'h9 || Out_Valid !== 1'b1) begin
      bad++; $display("FAIL b2b_first got=%h/%b exp=9/1", Data_Out, Out_Valid); end
    send_bit(frame_bit(4'h6, 0));
    total++; if (Out_Valid !== 1'b0 || Busy !== 1'b1) begin
      bad++; $display("FAIL b2b_gapless got=%b%b exp=01", Out_Valid, Busy); end
    for (int i = 1; i < FRAME; i++) send_bit(frame_bit(4'h6, i));
    total++; if (Data_Out !== 4'h6 || Out_Valid !== 1'b1 || Overrun !== 1'b0) begin
      bad++; $display("FAIL b2b_second got=%h/%b/%b exp=6/1/0", Data_Out, Out_Valid, Overrun); end
    tick();
    Out_Ready = 1'b0;
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    send_frame_p(4'hB, 1'b1);
    total++; if (Data_Out !== 4'hB || Parity_Err !== 1'b0) begin
      bad++; $display("FAIL par_good got=%h/%b exp=b/0", Data_Out, Parity_Err); end
    drain();
    send_frame_p(4'hB, 1'b0);
    total++; if (Data_Out !== 4'hB || Parity_Err !== 1'b1) begin
      bad++; $display("FAIL par_bad got=%h/%b exp=b/1", Data_Out, Parity_Err); end
    send_frame_p(4'h1, 1'b1);
    total++; if (Data_Out !== 4'hB || Parity_Err !== 1'b1 || Overrun !== 1'b1) begin
      bad++; $display("FAIL par_drop got=%h/%b/%b exp=b/1/1", Data_Out, Parity_Err, Overrun); end
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_overrun();
    test_drain_fill();
    test_reset_midframe();
    test_clear_midframe();
    test_back_to_back();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_frame_receiver.md
# sipo_frame_receiver

Serial-in/parallel-out frame receiver that sits directly downstream of the team's PISO shift register. It samples the LSB-first serial stream, gated by a per-bit valid qualifier, and assembles WIDTH-bit words. Each completed word is presented on a one-entry valid/ready output slot. Overrun is detected when a word completes while the slot is still occupied, and an optional even-parity check can be compiled in.

## Interface
- WIDTH, 4, data bits per frame (≥2)
- Clock  input  1  single clock; all state updates on posedge
- Reset  input  1  asynchronous, active-low; clears all state immediately
- SIn  input  1  serial data bit, LSB first
- SIn_Valid  input  1  SIn sampled only on cycles where this is 1; gaps allowed anywhere in a frame
- Clear  input  1  synchronous abort of the frame in progress; also clears Overrun
- Data_Out  output  WIDTH  last accepted word
- Out_Valid  output  1  output slot full
- Out_Ready  input  1  consumer accepts the word when Out_Valid && Out_Ready
- Overrun  output  1  sticky; a completed word was dropped
- Parity_Err  output  1  parity status of the word in Data_Out (0 when SIPO_PARITY_EN is undefined)
- Busy  output  1  frame partially received (bit counter ≠ 0)

## Operation
- FRAME = WIDTH, or WIDTH+1 with parity. Bit counter cnt runs 0..FRAME-1.
- Receive FSM:
  - IDLE (cnt=0) → RECV on the first valid bit.
  - RECV → IDLE when the last bit of the frame is sampled.
- Shift register, per valid data bit: sh <= {SIn, sh[WIDTH-1:1]}. The first bit received ends up in Data_Out[0].
- Frame completes when SIn_Valid=1 and cnt=FRAME-1. cnt wraps to 0. The completed word includes the bit sampled in that same cycle.
- Output slot states: EMPTY (Out_Valid=0) and FULL (Out_Valid=1).
  - Completion with slot EMPTY, or with slot FULL and Out_Ready=1 in the same cycle: load Data_Out and Parity_Err; Out_Valid=1.
  - Completion with slot FULL and Out_Ready=0: drop the word, set Overrun=1. Data_Out, Parity_Err and Out_Valid are unchanged.
  - Out_Valid && Out_Ready with no completion in that cycle: Out_Valid<=0. Data_Out holds its last value.
- Clear (synchronous):
  - Clears cnt, sh and Overrun. Clear takes priority over SIn_Valid; the bit in that cycle is discarded.
  - The output slot is unaffected. A handshake in the same cycle still completes.
- SIn is ignored when SIn_Valid=0. cnt and sh hold their values.

## Timing
- Reset values: Data_Out=0, Out_Valid=0, Overrun=0, Parity_Err=0, Busy=0. cnt and sh are also 0.
- Latency: Out_Valid rises on the clock edge that samples the last frame bit, so it is visible the cycle after that bit is presented.
- Back-to-back frames with continuous SIn_Valid: one word every FRAME cycles. No dead cycle between frames.
- Out_Ready is a combinational input. It is sampled only when Out_Valid=1, and a slot freed in cycle N can accept a word completing in cycle N.
- Reset asserted mid-frame or with the slot FULL: the partial frame and the pending word are lost. The block restarts in IDLE/EMPTY.
- Overrun stays set until Clear or Reset. It is independent of subsequent successful words.
- All outputs are registered except Busy, which is decoded from cnt.

## Configuration
- Macro: SIPO_PARITY_EN.
- Defined:
  - FRAME=WIDTH+1. The final bit is an even-parity bit and is not shifted into sh.
  - Parity_Err = XOR of the WIDTH data bits and the parity bit. It is captured with Data_Out and dropped along with the word on overrun.
- Undefined:
  - FRAME=WIDTH; Parity_Err is tied to 0.
  - No parity logic is synthesized; the port remains for interface stability.

## Test plan
- Basic word (WIDTH=4, no parity): SIn_Valid=1 for four cycles, SIn=1,0,1,1 → Data_Out=4'hD, Out_Valid=1 the next cycle, Busy=1 during bits 2–4.
- Gapped input: same bits with SIn_Valid=0 inserted between bits 2 and 3 for 3 cycles → Data_Out=4'hD, cnt holds during the gap.
- Overrun: Out_Ready=0; send 4'hA then 4'h5 → Data_Out stays 4'hA, Overrun=1. Clear → Overrun=0 and Out_Valid stays 1.
- Simultaneous drain and fill: slot holds 4'h3, Out_Ready=1 in the cycle the last bit of 4'hC is sampled → Data_Out=4'hC, Out_Valid stays 1, Overrun=0.
- Reset and Clear mid-frame:
  - Reset low after 2 bits → all outputs 0 immediately. The next 4 bits form a full word (e.g. 4'h6).
  - Clear with SIn_Valid=1 after 2 bits → that bit is dropped and Busy=0.
- Parity (SIPO_PARITY_EN): data 4'hB (bits 1,1,0,1) plus parity 1 → Parity_Err=0. Same data with parity 0 → Parity_Err=1, Data_Out=4'hB.
